cardinal_nic: RTL and testbench
===============================

# cardinal_nic

Network interface controller that sits on the Cardinal processor's data-memory port and connects it to one router port of the on-chip ring. The processor reaches four 64-bit memory-mapped registers (input buffer, input status, output buffer, output status) through a load/store-style port. The network side uses a one-deep send/ready handshake per direction, with virtual-channel polarity gating on output.

## Interface
Parameters:
- DATA_W, 64, width of a packet and of processor data
- ADDR_W, 2, register-select address width

Ports:
- Clock  in  1  system clock; all state changes on rising edge
- Reset  in  1  synchronous, active-high reset
- addr  in  [0:1]  register select: 00 in-buf, 01 in-status, 10 out-buf, 11 out-status
- d_in  in  [0:63]  processor store data
- d_out  out  [0:63]  processor load data
- nicEn  in  1  access enable
- nicWrEn  in  1  1 = write, 0 = read; qualified by nicEn
- net_si  in  1  router has a packet for the NIC
- net_ri  out  1  NIC input buffer can accept
- net_di  in  [0:63]  incoming packet
- net_so  out  1  NIC presents a packet to the router
- net_ro  in  1  router can accept
- net_do  out  [0:63]  outgoing packet
- net_polarity  in  1  router's current virtual channel (0 even, 1 odd)

## Operation
- State: in_buf[0:63], in_full, out_buf[0:63], out_full. No other state.
- Input channel: net_ri = ~in_full & ~Reset. On an edge with net_si & net_ri, in_buf <= net_di and in_full <= 1. When net_si is asserted while net_ri = 0, the packet is not taken; the router is responsible for holding it.
- Processor read (nicEn & ~nicWrEn): d_out is driven combinationally.
  - addr 00 -> in_buf.
  - addr 01 -> {63'b0, in_full}, with the flag in bit 63.
  - addr 10 -> out_buf.
  - addr 11 -> {63'b0, out_full}.
- d_out is 0 when nicEn = 0 or nicWrEn = 1.
- Side effect of a read at addr 00: if in_full = 1, in_full <= 0 at that edge.
- Reading addr 00 while in_full = 0 returns the stale in_buf and has no side effect.
- Processor write (nicEn & nicWrEn):
  - addr 10 with out_full = 0 (sampled before the edge): out_buf <= d_in and out_full <= 1.
  - addr 10 with out_full = 1: the write is dropped and all state is unchanged. This also applies when the buffer drains in the same cycle.
  - Writes to 00, 01 and 11 are ignored.
- Output channel:
  - net_do = out_buf at all times.
  - net_so = out_full & net_ro & vc_ok, where vc_ok = (out_buf[0] == net_polarity). Bit 0 of the packet is the VC bit.
  - Any cycle with net_so = 1 is a completed transfer; out_full <= 0 at that edge.
- Simultaneous events:
  - A network receive and a processor read of addr 00 cannot coincide on a full buffer, because net_ri = 0 while in_full = 1.
  - A read of addr 00 on a full buffer clears in_full at the edge. The router may deliver a new packet from the following cycle.
  - Output send and processor write on the same edge: the send completes and the write is dropped.

## Timing
- Reset values: in_buf = 0, in_full = 0, out_buf = 0, out_full = 0, d_out = 0, net_so = 0, net_do = 0.
- net_ri is 0 while Reset is high and 1 in the first cycle after Reset deasserts.
- Read latency is 0 cycles (combinational d_out). The status side effect lands at the same rising edge.
- Network receive to in_full visible on addr 01: next cycle.
- Processor write to net_so possible: next cycle, subject to net_ro and polarity.
- net_so and net_ri are combinational from registered flags and the router inputs. They have no combinational path from processor inputs.
- Reset mid-transfer: buffers and flags clear at the reset edge. Any handshake in that cycle is discarded.

## Configuration
- NIC_POLARITY_CHECK_EN
  - Defined: vc_ok = (out_buf[0] == net_polarity), as above.
  - Undefined: vc_ok = 1. net_polarity is ignored, and a full output buffer is sent whenever net_ro = 1.

## Test plan
- Reset: hold Reset 2 cycles, release -> all outputs 0; net_ri = 1 on the first post-reset cycle; status reads at 01 and 11 return 0.
- Receive then read:
  - net_si = 1, net_di = 64'hA5A5_0000_0000_0001 for one cycle -> net_ri = 0 next cycle; addr 01 reads 1.
  - Read addr 00 -> returns A5A5_0000_0000_0001; next cycle addr 01 reads 0 and net_ri = 1.
- Output polarity (macro defined):
  - Write addr 10 with d_in[0] = 1, net_ro = 1, net_polarity = 0 -> net_so stays 0.
  - Toggle net_polarity to 1 -> net_so = 1 for exactly one cycle, then addr 11 reads 0.
- Output backpressure: out_full = 1, net_ro = 0 for 5 cycles, processor writes 64'h1234 to addr 10 -> write dropped; net_do unchanged; net_so asserts once net_ro = 1.
- Same-edge send and write: out_full = 1, send completes in cycle N while the processor writes 64'hBEEF -> out_full = 0 after N; out_buf holds the old packet; BEEF is lost.
- Macro undefined: packet with bit 0 = 0, net_polarity = 1, net_ro = 1 -> net_so = 1 on the cycle after the write.

Source files
------------

// File: rtl/cardinal_nic.sv
// Cardinal NIC: four 64-bit processor-mapped registers bridging a data-memory port to one ring router port.
// Reads are combinational; one-deep buffer per direction. Define NIC_POLARITY_CHECK_EN to gate sends on VC polarity.
module cardinal_nic #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 2
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [0:ADDR_W-1] addr,
  input  logic [0:DATA_W-1] d_in,
  output logic [0:DATA_W-1] d_out,
  input  logic              nicEn,
  input  logic              nicWrEn,
  input  logic              net_si,
  output logic              net_ri,
  input  logic [0:DATA_W-1] net_di,
  output logic              net_so,
  input  logic              net_ro,
  output logic [0:DATA_W-1] net_do,
  input  logic              net_polarity
);

  localparam logic [0:ADDR_W-1] A_IN_BUF  = ADDR_W'(0);
  localparam logic [0:ADDR_W-1] A_IN_STS  = ADDR_W'(1);
  localparam logic [0:ADDR_W-1] A_OUT_BUF = ADDR_W'(2);
  localparam logic [0:ADDR_W-1] A_OUT_STS = ADDR_W'(3);

  logic [0:DATA_W-1] in_buf_q, in_buf_d;
  logic [0:DATA_W-1] out_buf_q, out_buf_d;
  logic              in_full_q, in_full_d;
  logic              out_full_q, out_full_d;
  logic              rd_en, wr_en, vc_ok;

  assign rd_en = nicEn & ~nicWrEn;
  assign wr_en = nicEn & nicWrEn;

  // Bit 0 (MSB in this numbering) of an outgoing packet selects its virtual channel.
`ifdef NIC_POLARITY_CHECK_EN
  assign vc_ok = (out_buf_q[0] == net_polarity);
`else
  logic unused_polarity;
  assign unused_polarity = net_polarity;
  assign vc_ok = 1'b1;
`endif

  assign net_ri = ~in_full_q & ~Reset;
  assign net_so = out_full_q & net_ro & vc_ok;
  assign net_do = out_buf_q;

  always_comb begin
    d_out = '0;
    if (rd_en) begin
      case (addr)
        A_IN_BUF:  d_out = in_buf_q;
        A_IN_STS:  d_out = {{(DATA_W-1){1'b0}}, in_full_q};
        A_OUT_BUF: d_out = out_buf_q;
        A_OUT_STS: d_out = {{(DATA_W-1){1'b0}}, out_full_q};
        default:   d_out = '0;
      endcase
    end
  end

  always_comb begin
    in_buf_d   = in_buf_q;
    in_full_d  = in_full_q;
    out_buf_d  = out_buf_q;
    out_full_d = out_full_q;

    // Receive and draining read are exclusive: net_ri is low whenever the buffer is full.
    if (net_si && net_ri) begin
      in_buf_d  = net_di;
      in_full_d = 1'b1;
    end else if (rd_en && addr == A_IN_BUF && in_full_q) begin
      in_full_d = 1'b0;
    end

    // A write only lands on an empty buffer, so a same-edge send always wins.
    if (out_full_q) begin
      if (net_so) out_full_d = 1'b0;
    end else if (wr_en && addr == A_OUT_BUF) begin
      out_buf_d  = d_in;
      out_full_d = 1'b1;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      in_buf_q   <= '0;
      in_full_q  <= 1'b0;
      out_buf_q  <= '0;
      out_full_q <= 1'b0;
    end else begin
      in_buf_q   <= in_buf_d;
      in_full_q  <= in_full_d;
      out_buf_q  <= out_buf_d;
      out_full_q <= out_full_d;
    end
  end

endmodule

// File: tb/tb_cardinal_nic.sv
// Self-checking bench for cardinal_nic: directed scenarios plus random traffic against a queue-based model.
module tb_cardinal_nic;

  logic        Clock = 1'b0;
  logic        Reset;
  logic [0:1]  addr;
  logic [0:63] d_in, d_out, net_di, net_do;
  logic        nicEn, nicWrEn, net_si, net_ri, net_so, net_ro, net_polarity;

  cardinal_nic #(.DATA_W(64), .ADDR_W(2)) dut (
    .Clock(Clock), .Reset(Reset), .addr(addr), .d_in(d_in), .d_out(d_out),
    .nicEn(nicEn), .nicWrEn(nicWrEn), .net_si(net_si), .net_ri(net_ri),
    .net_di(net_di), .net_so(net_so), .net_ro(net_ro), .net_do(net_do),
    .net_polarity(net_polarity)
  );

  always #5 Clock = ~Clock;

  int total = 0;
  int bad   = 0;

  // Model: each direction is a queue of at most one pending packet plus the last packet stored.
  logic [0:63] in_q[$];
  logic [0:63] out_q[$];
  logic [0:63] in_last  = '0;
  logic [0:63] out_last = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle();
    Reset = 1'b0; addr = 2'd0; d_in = '0; nicEn = 1'b0; nicWrEn = 1'b0;
    net_si = 1'b0; net_di = '0; net_ro = 1'b0; net_polarity = 1'b0;
  endtask

  // One clock: check outputs mid-cycle against the model, then advance the model at the edge.
  task automatic step(input bit check);
    logic [0:63] exp_dout;
    bit vc, eso, eri, rd;
    @(negedge Clock);
    eri = (in_q.size() == 0) && !Reset;
`ifdef NIC_POLARITY_CHECK_EN
    vc = (out_last[0] == net_polarity);
`else
    vc = 1'b1;
`endif
    eso = (out_q.size() != 0) && net_ro && vc;
    rd = nicEn && !nicWrEn;
    exp_dout = '0;
    if (rd) begin
      case (addr)
        2'd0: exp_dout = in_last;
        2'd1: exp_dout = (in_q.size() != 0) ? 64'd1 : 64'd0;
        2'd2: exp_dout = out_last;
        default: exp_dout = (out_q.size() != 0) ? 64'd1 : 64'd0;
      endcase
    end
    if (check) begin
      chk("net_ri", {63'd0, net_ri}, {63'd0, eri});
      chk("net_so", {63'd0, net_so}, {63'd0, eso});
      chk("net_do", net_do, out_last);
      chk("d_out", d_out, exp_dout);
    end
    @(posedge Clock);
    if (Reset) begin
      in_q.delete(); out_q.delete();
      in_last = '0; out_last = '0;
    end else begin
      if (eri && net_si) begin
        in_q.push_back(net_di);
        in_last = net_di;
      end else if (rd && addr == 2'd0 && in_q.size() != 0) begin
        void'(in_q.pop_front());
      end
      if (eso) begin
        void'(out_q.pop_front());
      end else if (nicEn && nicWrEn && addr == 2'd2 && out_q.size() == 0) begin
        out_q.push_back(d_in);
        out_last = d_in;
      end
    end
    #1;
  endtask

  task automatic proc(input bit en, input bit wr, input logic [0:1] a, input logic [0:63] d);
    nicEn = en; nicWrEn = wr; addr = a; d_in = d;
  endtask

  initial begin
    idle();
    Reset = 1'b1;
    step(0);
    step(1);
    Reset = 1'b0;
    step(1);
    proc(1, 0, 2'd1, '0); step(1);
    proc(1, 0, 2'd3, '0); step(1);

    // Receive then read back with drain.
    net_si = 1'b1; net_di = 64'hA5A5_0000_0000_0001; proc(0, 0, 2'd0, '0); step(1);
    net_si = 1'b0; proc(1, 0, 2'd1, '0); step(1);
    proc(1, 0, 2'd0, '0); step(1);
    proc(1, 0, 2'd1, '0); step(1);
    proc(1, 0, 2'd0, '0); step(1);

    // Polarity gating with VC bit set.
    idle();
    net_ro = 1'b1; net_polarity = 1'b0;
    proc(1, 1, 2'd2, 64'h8000_0000_0000_0055); step(1);
    proc(0, 0, 2'd0, '0); step(1); step(1);
    net_polarity = 1'b1; step(1); step(1);
    proc(1, 0, 2'd3, '0); step(1);

    // Backpressure: writes to a full buffer are dropped.
    idle();
    proc(1, 1, 2'd2, 64'h0000_0000_0000_0077); step(1);
    for (int i = 0; i < 5; i++) begin
      proc(1, 1, 2'd2, 64'h1234); step(1);
    end
    proc(0, 0, 2'd0, '0); net_ro = 1'b1; step(1); step(1);

    // Same-edge send and write: the write is lost.
    idle();
    proc(1, 1, 2'd2, 64'h0000_0000_0000_0099); step(1);
    net_ro = 1'b1; proc(1, 1, 2'd2, 64'hBEEF); step(1);
    net_ro = 1'b0; proc(1, 0, 2'd3, '0); step(1);
    proc(1, 0, 2'd2, '0); step(1);

    // VC bit clear with odd polarity: only sends when the check is compiled out.
    idle();
    net_ro = 1'b1; net_polarity = 1'b1;
    proc(1, 1, 2'd2, 64'h0000_0000_0000_0042); step(1);
    proc(0, 0, 2'd0, '0); step(1);
    net_polarity = 1'b0; step(1); step(1);

    for (int i = 0; i < 3000; i++) begin
      Reset        = ($urandom_range(0, 199) == 0);
      nicEn        = $urandom_range(0, 1);
      nicWrEn      = $urandom_range(0, 1);
      addr         = 2'($urandom_range(0, 3));
      d_in         = {$urandom, $urandom};
      net_si       = ($urandom_range(0, 2) != 0);
      net_di       = {$urandom, $urandom};
      net_ro       = $urandom_range(0, 1);
      net_polarity = $urandom_range(0, 1);
      step(1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
